serial_adder_fsm: RTL and testbench
===================================

# serial_adder_fsm

Parametrised bit-serial adder/subtractor built around a Mealy carry FSM. It is the multi-bit successor to the single-bit half-adder FSM. It accepts two WIDTH-bit operands through a valid/ready handshake and processes one bit per clock, LSB first. A single carry flip-flop holds the running state. Per-bit Mealy outputs and a registered word result are both exposed. The block sits between operand producers and result consumers in the arithmetic FSM examples.

## Interface
- WIDTH, 8: operand and result width in bits; legal range is 1 or more.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 selects A+B; 1 selects A−B. Sampled at accept.
- bit_valid  out  1  sum_bit and carry_bit are meaningful this cycle.
- sum_bit  out  1  Mealy sum of the current bit.
- carry_bit  out  1  Mealy carry-out of the current bit.
- out_valid  out  1  word result available.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  word result, modulo 2^WIDTH.
- cout  out  1  final carry. For subtraction, cout=1 means no borrow.
- ovf  out  1  two's-complement signed overflow.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset** (rst=0 at an edge):
  - State goes to IDLE.
  - All registers clear; every output is 0 except in_ready=1.
  - Reset has priority over every other event, including mid-RUN and in DONE. A partial result is discarded and out_valid is never raised for it.
- **Accept** (in_valid & in_ready at an edge):
  - Load shift registers: A ← a; B ← (sub ? ~b : b).
  - Carry ← sub. Bit counter ← 0. State → RUN.
- **RUN, each cycle:**
  - Combinational outputs: sum_bit = A[0]^B[0]^carry and carry_bit = majority(A[0], B[0], carry); bit_valid=1.
  - At the edge:
    - Shift sum_bit into the result register from the MSB side.
    - Shift A and B right.
    - Carry ← carry_bit.
    - Counter increments.
  - On the edge that processes bit WIDTH-1:
    - Latch cout ← carry_bit.
    - Latch ovf ← carry-in XOR carry-out of bit WIDTH-1.
    - State → DONE.
- **DONE:**
  - out_valid=1. sum, cout and ovf hold stable until out_ready=1 at an edge.
  - in_ready = out_ready. This allows back-to-back operation: if out_ready and in_valid are both high at the same edge, the result is released and the new operands are accepted, going straight to RUN.
  - If out_ready=1 and in_valid=0, state → IDLE.
- **In IDLE and DONE:** bit_valid=0, and sum_bit and carry_bit are driven 0.
- **In RUN:** in_ready=0. in_valid, a, b and sub are ignored.
- **Counter:** width is $clog2(WIDTH), minimum 1 bit. No wrap occurs within a word.

## Timing
- Accept at edge E. Bits are processed at edges E+1 … E+WIDTH.
- out_valid rises after edge E+WIDTH. Latency from accept to out_valid is WIDTH cycles.
- Sustained throughput: one word per WIDTH+1 cycles when out_ready is held high.
- Bit i's Mealy outputs are valid during the cycle before edge E+1+i.
- in_ready is combinational from state and out_ready. No other combinational input-to-output paths exist except the Mealy bit outputs.
- WIDTH=1: a single RUN cycle, then DONE.

## Structure
- **Package `serial_adder_pkg`:**
  - State enum {IDLE, RUN, DONE}, 2-bit encoding.
  - Localparam helper for counter width.
- **Sub-module `full_adder_cell`:** combinational 1-bit (a, b, cin) → (s, cout). Instantiated once. The FSM, shift registers and handshake live in the top module.

## Test plan
- **Basic add** (WIDTH=8): a=0x35, b=0x4A, sub=0 → out_valid 8 cycles after accept; sum=0x7F, cout=0, ovf=0. The sum_bit sequence, LSB first, is 1,1,1,1,1,1,1,0.
- **Carry wrap:** a=0xFF, b=0x01, sub=0 → sum=0x00, cout=1, ovf=0.
- **Signed overflow and subtract:**
  - a=0x7F, b=0x01, sub=0 → sum=0x80, ovf=1.
  - a=0x05, b=0x07, sub=1 → sum=0xFE, cout=0 (borrow), ovf=0.
- **Back-to-back:** hold out_ready=1 and in_valid=1 with operand pairs (0x10,0x20) then (0x01,0x02) → results 0x30 then 0x03. The second out_valid arrives exactly 9 cycles after the first. in_ready is never high during RUN.
- **Backpressure:** out_ready=0 for 5 cycles in DONE → sum, cout and ovf are stable and in_valid is ignored. Raising out_ready releases the result and the state goes to IDLE.
- **Reset mid-operation:** rst=0 at bit 3 of a run → the next cycle is IDLE, in_ready=1, and all other outputs are 0. No out_valid occurs. Repeat with WIDTH=1, a=1, b=1 → sum=0, cout=1, latency 1.

Source files
------------

// File: rtl/serial_adder_fsm_pkg.sv
// rtl/serial_adder_fsm_pkg.sv - state encoding and counter sizing for the bit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - combinational one-bit full adder
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_fsm.sv
// rtl/serial_adder_fsm.sv - LSB-first bit-serial adder/subtractor with Mealy carry FSM
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             bit_valid,
  output logic             sum_bit,
  output logic             carry_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  import serial_adder_pkg::*;

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               fa_s, fa_c;
  logic               running;
  logic               accept;

  full_adder_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign running   = (state_q == ST_RUN);
  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign bit_valid = running;
  assign sum_bit   = running & fa_s;
  assign carry_bit = running & fa_c;
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (state_q == ST_DONE && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d   = WIDTH'({fa_s, sum_q} >> 1);
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// tb/tb_serial_adder_fsm.sv - scoreboard bench for serial_adder_fsm (WIDTH=8 and WIDTH=1)
module tb_serial_adder_fsm;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, sub, bit_valid, sum_bit, carry_bit;
  logic         out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  logic         rst_1, in_valid_1, in_ready_1, sub_1, bit_valid_1, sum_bit_1, carry_bit_1;
  logic         out_valid_1, out_ready_1, cout_1, ovf_1;
  logic [0:0]   a_1, b_1, sum_1;

  serial_adder_fsm #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .bit_valid(bit_valid), .sum_bit(sum_bit),
    .carry_bit(carry_bit), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_adder_fsm #(.WIDTH(1)) dut_1 (
    .clk(clk), .rst(rst_1), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .a(a_1), .b(b_1), .sub(sub_1), .bit_valid(bit_valid_1), .sum_bit(sum_bit_1),
    .carry_bit(carry_bit_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
    .sum(sum_1), .cout(cout_1), .ovf(ovf_1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   rise_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Arithmetic reference: integer sum/difference, signed range test for overflow.
  function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib, input logic isub);
    exp_t e;
    int   s;
    int   r;
    e.a   = ia;
    e.b   = ib;
    e.sub = isub;
    s = isub ? int'(ia) - int'(ib) : int'(ia) + int'(ib);
    r = isub ? int'($signed(ia)) - int'($signed(ib)) : int'($signed(ia)) + int'($signed(ib));
    e.sum  = s[7:0];
    e.cout = isub ? (ia >= ib) : (s > 255);
    e.ovf  = (r > 127) || (r < -128);
    return e;
  endfunction

  // Carry out of bit i: does the low (i+1)-bit slice overflow (add) or not borrow (sub)?
  function automatic logic exp_carry(input exp_t e, input int i);
    int m;
    int am;
    int bm;
    m  = 1 << (i + 1);
    am = int'(e.a) % m;
    bm = int'(e.b) % m;
    return e.sub ? (am >= bm) : (am + bm >= m);
  endfunction

  initial begin : monitor
    int   bit_idx;
    logic prev_ov;
    exp_t e;
    bit_idx = 0;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        exp_q.delete();
        acc_q.delete();
        bit_idx = 0;
        prev_ov = 1'b0;
      end else begin
        if (bit_valid) begin
          chk("in_ready_in_run", in_ready, 0);
          if (exp_q.size() == 0 || bit_idx >= W) chk("unexpected_bit", 1, 0);
          else begin
            chk("sum_bit", sum_bit, exp_q[0].sum[bit_idx]);
            chk("carry_bit", carry_bit, exp_carry(exp_q[0], bit_idx));
          end
          bit_idx++;
        end
        if (out_valid && !prev_ov) begin
          rise_q.push_back(cyc);
          if (acc_q.size() == 0) chk("unexpected_out_valid", 1, 0);
          else chk("latency", cyc - acc_q.pop_front(), W);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("sum", sum, e.sum);
            chk("cout", cout, e.cout);
            chk("ovf", ovf, e.ovf);
          end
          bit_idx = 0;
        end
        if (in_valid && in_ready) acc_q.push_back(cyc + 1);
        prev_ov = out_valid;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic isub);
    bit   got;
    exp_t e;
    a = ia;
    b = ib;
    sub = isub;
    in_valid = 1'b1;
    e = model(ia, ib, isub);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) chk("accept_timeout", 0, 1);
    else exp_q.push_back(e);
    step();
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic run_dir(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                         input logic [7:0] esum, input logic ecout, input logic eovf);
    out_ready = 1'b0;
    issue(ia, ib, isub);
    in_valid = 1'b0;
    wait_done();
    chk("dir_sum", sum, esum);
    chk("dir_cout", cout, ecout);
    chk("dir_ovf", ovf, eovf);
    step();
    out_ready = 1'b1;
    step();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int         n0;
    int         cnt;
    bit         rel;
    exp_t       e;
    logic [7:0] ra, rb;
    logic [7:0] corner [4];
    corner[0] = 8'h00; corner[1] = 8'hFF; corner[2] = 8'h80; corner[3] = 8'h7F;

    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    rst_1 = 1'b0; in_valid_1 = 1'b0; a_1 = '0; b_1 = '0; sub_1 = 1'b0; out_ready_1 = 1'b0;
    step(); step(); step();
    @(negedge clk);
    chk("reset_state", {in_ready, out_valid, bit_valid, sum_bit, carry_bit, cout, ovf, sum},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    step();
    rst = 1'b1;
    step();

    run_dir(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_dir(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_dir(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_dir(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);

    // Back-to-back: second accept shares the edge that releases the first result.
    out_ready = 1'b1;
    n0 = rise_q.size();
    issue(8'h10, 8'h20, 1'b0);
    issue(8'h01, 8'h02, 1'b0);
    in_valid = 1'b0;
    wait_done();
    chk("b2b_sum2", sum, 8'h03);
    step();
    if (rise_q.size() >= n0 + 2) chk("b2b_gap", rise_q[n0+1] - rise_q[n0], W + 1);
    else chk("b2b_missing_result", rise_q.size() - n0, 2);

    out_ready = 1'b0;
    e = model(8'h5A, 8'h33, 1'b1);
    issue(8'h5A, 8'h33, 1'b1);
    in_valid = 1'b0;
    wait_done();
    step();
    a = 8'hAA; b = 8'h55; sub = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold", {out_valid, in_ready, bit_valid, sum_bit, carry_bit, sum, cout, ovf},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e.sum, e.cout, e.ovf});
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_to_idle", {out_valid, in_ready, bit_valid}, 3'b010);
    step();

    issue(8'h12, 8'h34, 1'b0);
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("rst_mid", {in_ready, out_valid, bit_valid, sum_bit, carry_bit, cout, ovf, sum},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    step();
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("no_out_after_rst", cnt, 0);
    step();

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      issue(ra, rb, 1'($urandom_range(0, 1)));
      in_valid = 1'b0;
      rel = 1'b0;
      for (int k = 0; k < 300 && !rel; k++) begin
        @(negedge clk);
        if (out_valid && out_ready) rel = 1'b1;
        else begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      if (!rel) chk("release_timeout", 0, 1);
      step();
    end
    chk("queue_drained", exp_q.size(), 0);

    @(negedge clk);
    chk("w1_reset", {in_ready_1, out_valid_1, bit_valid_1, sum_1, cout_1, ovf_1}, 6'b100000);
    step();
    rst_1 = 1'b1;
    out_ready_1 = 1'b1;
    a_1 = 1'b1; b_1 = 1'b1; sub_1 = 1'b0; in_valid_1 = 1'b1;
    @(negedge clk);
    chk("w1_in_ready", in_ready_1, 1);
    step();
    in_valid_1 = 1'b0;
    @(negedge clk);
    chk("w1_bit", {bit_valid_1, sum_bit_1, carry_bit_1, out_valid_1}, 4'b1010);
    step();
    @(negedge clk);
    chk("w1_result", {out_valid_1, sum_1, cout_1, ovf_1}, 4'b1011);
    step();
    a_1 = 1'b1; b_1 = 1'b0; in_valid_1 = 1'b1;
    step();
    in_valid_1 = 1'b0;
    rst_1 = 1'b0;
    step();
    @(negedge clk);
    chk("w1_rst_mid", {in_ready_1, out_valid_1, bit_valid_1, sum_1, cout_1, ovf_1}, 6'b100000);
    step();
    rst_1 = 1'b1;
    step();
    @(negedge clk);
    chk("w1_no_out", out_valid_1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
